sram_like_resp_mem: RTL
=======================

Name: sram_like_resp_mem

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface that the fetch and memory stages use as initiators.
- Backs the interface with an internal word-addressed synchronous RAM.
- Accepts up to DEPTH outstanding requests and returns responses strictly in order after a configurable delay.
- Used as the instruction/data memory model in the SoC-lite top and as the attach point for verifying initiator cancel logic.

Parameters:
- ADDR_W, 12: RAM index width; memory holds 2^ADDR_W 32-bit words.
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests (2..4).
- RESP_DELAY, 1: cycles from accept to data_ok. A value of 0 is treated as 1.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  1  initiator request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb is authoritative for writes
- addr  in  32  byte address
- wstrb  in  4  byte enables for writes
- wdata  in  32  write data
- stall_addr  in  1  test hook; forces addr_ok low
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  response for oldest outstanding request
- rdata  out  32  read data, valid with data_ok

Behaviour:
- Reset (asynchronous, resetn low):
  - Queue emptied; addr_ok = 0, data_ok = 0, rdata = 0.
  - RAM contents are not cleared and are retained across reset.
- Handshake:
  - addr_ok = req & ~full & ~stall_addr. Combinational; it may rise in the same cycle as req.
  - Accept = req & addr_ok at the rising edge.
  - The initiator must hold inputs stable until accept; the block does not check this.
- full / empty:
  - count == DEPTH means full. No same-cycle bypass: while full, addr_ok stays 0 even if the head retires that cycle.
  - count == 0 means empty: data_ok = 0.
- Address mapping: index = addr[ADDR_W+1:2]. Upper bits alias; addr[1:0] is ignored.
- Write: RAM bytes with wstrb[i] = 1 are updated at the accept edge; bytes with wstrb[i] = 0 are unchanged.
- Read:
  - RAM is read at the accept edge (synchronous RAM).
  - Data is captured into the entry the next cycle.
  - A read accepted after a write to the same index returns the written bytes.
- Queue entry: {is_wr, data[31:0], cnt}.
  - cnt is loaded with max(RESP_DELAY,1)-1 at accept.
  - cnt decrements each cycle while nonzero.
  - Non-head entries saturate at 0 and wait.
- Response:
  - data_ok = 1 when the queue is non-empty, the head cnt == 0, and the head was accepted at least one edge ago.
  - Head retires on the edge where data_ok = 1. At most one response per cycle; strictly in order.
  - Latency from accept edge to data_ok cycle is exactly max(RESP_DELAY,1) when the queue ahead is drained.
- rdata = head data when data_ok & ~is_wr; otherwise 0.
- data_ok has no backpressure. The initiator must absorb every response; canceled fetches are discarded by the initiator, never by this block.
- Simultaneous accept and retire: count unchanged; the new entry goes behind the remaining ones.
- Pointers are modulo DEPTH; count is width clog2(DEPTH+1).
- Reset asserted mid-operation: all outstanding responses are dropped. No data_ok appears after deassertion for pre-reset requests.

Test Plan:
- Preload RAM[0x10] = 0xDEADBEEF; RESP_DELAY = 1; read addr 0x40 -> addr_ok the same cycle; data_ok exactly 1 cycle after accept with rdata = 0xDEADBEEF; rdata = 0 otherwise.
- DEPTH = 2, RESP_DELAY = 3; hold req high for reads to 0x0, 0x4, 0x8 -> first two accepted on consecutive cycles; addr_ok low while full; third accepted only after the first data_ok; responses arrive in order.
- Word write 0x11223344 to 0x100; then write wstrb = 4'b0101, wdata = 0xAABBCCDD; then read 0x100 -> rdata = 0x11BB33DD; write response data_ok shows rdata = 0.
- Assert stall_addr for 5 cycles with req high -> addr_ok = 0 throughout; accept occurs on the first cycle after release; latency unchanged.
- Two reads outstanding; pull resetn low asynchronously mid-cycle -> data_ok/addr_ok drop immediately; after release, no stray data_ok; RAM contents are intact on re-read.
- RESP_DELAY = 0, ADDR_W = 4: read addr 0x40 -> aliases to index 0; data_ok after 1 cycle (same as RESP_DELAY = 1).

Source files
------------

// File: rtl/sram_like_resp_mem_if.sv
// Request/response bundle of the SRAM-like req/addr_ok/data_ok bus.
// The initiator (fetch/memory stage) is the master; the memory model is the slave.
interface sram_like_resp_mem_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_resp_mem.sv
// SRAM-like bus responder backed by a word-addressed synchronous RAM.
// Accepts up to DEPTH outstanding requests and answers them strictly in
// order, each no earlier than max(RESP_DELAY,1) cycles after its accept.
module sram_like_resp_mem #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 2,
    parameter int RESP_DELAY = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                stall_addr,
    sram_like_resp_mem_if.slave bus
);

    localparam int DLY   = (RESP_DELAY < 1) ? 1 : RESP_DELAY;
    localparam int DC_W  = (DLY > 1) ? $clog2(DLY) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] idx;

    logic              q_wr   [DEPTH];
    logic [31:0]       q_data [DEPTH];
    logic [DC_W-1:0]   q_cnt  [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              cap_pend;
    logic [PTR_W-1:0]  cap_ptr;

    logic              full;
    logic              accept;
    logic              retire;
    logic              addr_ok_c;
    logic              data_ok_c;
    logic [31:0]       head_data;
    logic [31:0]       rdata_c;
    logic              unused_ok;

    assign idx       = bus.addr[ADDR_W+1:2];
    assign unused_ok = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, head selection and response outputs.
    // A read's RAM word sits in ram_q for one cycle before it lands in its
    // queue slot, so the head is bypassed from ram_q during that cycle.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        addr_ok_c = resetn & bus.req & ~full & ~stall_addr;
        accept    = bus.req & addr_ok_c;
        data_ok_c = (count != '0) && (q_cnt[rd_ptr] == '0);
        retire    = data_ok_c;
        head_data = (cap_pend && (cap_ptr == rd_ptr)) ? ram_q : q_data[rd_ptr];
        rdata_c   = (data_ok_c && !q_wr[rd_ptr]) ? head_data : '0;
    end

    assign bus.addr_ok = addr_ok_c;
    assign bus.data_ok = data_ok_c;
    assign bus.rdata   = rdata_c;

    // RAM port: byte-masked write or registered read at the accept edge; never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.wr) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (bus.wstrb[b]) begin
                        mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                    end
                end
            end else begin
                ram_q <= mem[idx];
            end
        end
    end

    // Outstanding-request queue: enqueue on accept, retire head on data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cap_pend <= 1'b0;
            cap_ptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_wr[i]   <= 1'b0;
                q_data[i] <= '0;
                q_cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (q_cnt[i] != '0) begin
                    q_cnt[i] <= q_cnt[i] - DC_W'(1);
                end
            end

            if (accept) begin
                q_wr[wr_ptr]  <= bus.wr;
                q_cnt[wr_ptr] <= DC_W'(DLY - 1);
                wr_ptr        <= ptr_inc(wr_ptr);
            end

            cap_pend <= accept & ~bus.wr;
            cap_ptr  <= wr_ptr;
            if (cap_pend) begin
                q_data[cap_ptr] <= ram_q;
            end

            if (retire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({accept, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
